// File: rtl/sv_timer_irq.sv
// Multi-channel programmable interval timer with a shared IRQ and one CPU register window.
// Latency: register writes land on the next clk edge, dout is registered, irq is a pure AND-OR of registered state.
// Backpressure: none; the bus is always ready and timer logic advances only on ce.
//
// Ports:
//   clk    system clock                 reset  async active-high reset
//   ce     CPU-rate tick enable         cs     register window select
//   we     1=write / 0=read             addr   register offset (4 bits)
//   din    write data (8 bits)          dout   registered read data (8 bits)
//   irq    level IRQ, active-high
//
// Register map, channel n at base 4n:
//   +0 reload[7:0]  +1 reload[15:8]  +2 ctrl  +3 count[7:0] (read-only)
//   ctrl[0] enable, ctrl[1] long prescale, ctrl[2] auto-reload, ctrl[3] irq enable
//   0xC status (W1C)  0xD count[15:8] of channel in 0xE  0xE channel select
module sv_timer_irq #(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 8,
    parameter int PRE_SHORT = 256,
    parameter int PRE_LONG  = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);
    localparam int PRE_W = $clog2(PRE_LONG);
    localparam logic [PRE_W-1:0] PRE_S_M1 = PRE_W'(PRE_SHORT - 1);
    localparam logic [PRE_W-1:0] PRE_L_M1 = PRE_W'(PRE_LONG - 1);

    logic              wr;
    logic              rd;
    logic              wr_stat;
    logic              wr_sel;
    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] ien_vec;
    logic [15:0]       rl_vec  [NUM_CH];
    logic [15:0]       cnt_vec [NUM_CH];
    logic [3:0]        ctl_vec [NUM_CH];
    logic [1:0]        sel_q;
    logic [1:0]        sel_d;
    logic [7:0]        dout_q;
    logic [7:0]        dout_d;

    assign wr      = cs & we;
    assign rd      = cs & ~we;
    assign wr_stat = wr && (addr == 4'hC);
    assign wr_sel  = wr && (addr == 4'hE);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic             wr_lo;
        logic             wr_hi;
        logic             wr_ctl;
        logic             commit;
        logic             tick;
        logic             fire;
        logic [CNT_W-1:0] reload_q, reload_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [3:0]       ctrl_q, ctrl_d;
        logic [PRE_W-1:0] pre_q, pre_d;
        logic [PRE_W-1:0] pre_rld;
        logic             pend_q, pend_d;

        assign wr_lo  = wr && (addr == {2'(n), 2'd0});
        assign wr_hi  = wr && (addr == {2'(n), 2'd1});
        assign wr_ctl = wr && (addr == {2'(n), 2'd2});
        // The load is committed by the byte that completes the counter width.
        assign commit = (CNT_W > 8) ? wr_hi : wr_lo;
        assign pre_rld = ctrl_q[1] ? PRE_L_M1 : PRE_S_M1;
        assign tick    = ce && ctrl_q[0] && (pre_q == '0);

        always_comb begin
            reload_d = reload_q;
            for (int b = 0; b < CNT_W; b++) begin
                if ((b < 8) ? wr_lo : wr_hi) begin
                    reload_d[b] = din[b[2:0]];
                end
            end
            ctrl_d = wr_ctl ? din[3:0] : ctrl_q;

            // Prescaler: load commit and a select change restart the period;
            // a disabled channel parks at the top of the period.
            if (commit) begin
                pre_d = pre_rld;
            end else if (wr_ctl && (din[1] != ctrl_q[1])) begin
                pre_d = din[1] ? PRE_L_M1 : PRE_S_M1;
            end else if (!ctrl_q[0]) begin
                pre_d = pre_rld;
            end else if (ce) begin
                pre_d = (pre_q == '0) ? pre_rld : pre_q - PRE_W'(1);
            end else begin
                pre_d = pre_q;
            end

            // Counter: commit overrides a coincident tick.
            fire    = 1'b0;
            count_d = count_q;
            if (commit) begin
                count_d = reload_d;
                fire    = ctrl_q[0] && (reload_d == '0);
            end else if (tick) begin
                if (count_q == CNT_W'(1)) begin
                    fire    = 1'b1;
                    count_d = ctrl_q[2] ? reload_q : '0;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            // A new event beats a same-cycle W1C.
            pend_d = fire | (pend_q & ~(wr_stat & din[n]));
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                reload_q <= '0;
                count_q  <= '0;
                ctrl_q   <= '0;
                pre_q    <= PRE_S_M1;
                pend_q   <= 1'b0;
            end else begin
                reload_q <= reload_d;
                count_q  <= count_d;
                ctrl_q   <= ctrl_d;
                pre_q    <= pre_d;
                pend_q   <= pend_d;
            end
        end

        assign pend_vec[n] = pend_q;
        assign ien_vec[n]  = ctrl_q[3];
        assign rl_vec[n]   = 16'(reload_q);
        assign cnt_vec[n]  = 16'(count_q);
        assign ctl_vec[n]  = ctrl_q;
    end

    assign sel_d = wr_sel ? din[1:0] : sel_q;

    // Read mux; absent channels and holes in the map read as all-ones.
    always_comb begin
        dout_d = 8'hFF;
        if (addr[3:2] != 2'd3) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (addr[3:2] == 2'(n)) begin
                    case (addr[1:0])
                        2'd0:    dout_d = rl_vec[n][7:0];
                        2'd1:    dout_d = rl_vec[n][15:8];
                        2'd2:    dout_d = {4'h0, ctl_vec[n]};
                        default: dout_d = cnt_vec[n][7:0];
                    endcase
                end
            end
        end else begin
            case (addr[1:0])
                2'd0: dout_d = 8'(pend_vec);
                2'd1: begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        if (sel_q == 2'(n)) begin
                            dout_d = cnt_vec[n][15:8];
                        end
                    end
                end
                2'd2:    dout_d = {6'h00, sel_q};
                default: dout_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= 2'd0;
            dout_q <= 8'h00;
        end else begin
            sel_q <= sel_d;
            if (rd) begin
                dout_q <= dout_d;
            end
        end
    end

    assign dout = dout_q;
    assign irq  = |(pend_vec & ien_vec);

endmodule
